merge2_stage: RTL
=================

Name: merge2_stage

Overview:
- Two-way merge stage that sits directly downstream of a pair of fifo16 buffers.
- Each buffer holds sorted ascending runs of 2**LOG2_RUN words.
- The block peeks both heads through the buffers' dcmp/empty outputs and pops the smaller head with rd_en.
- It emits one merged sorted run of 2*2**LOG2_RUN words per input run pair, through a registered valid/ready output that feeds the next fifo16 or merge level.

Parameters:
- DATA_WIDTH, 32, width of key/data word; compared as unsigned.
- LOG2_RUN, 4, log2 of input run length (RUN = 2**LOG2_RUN); LOG2_RUN >= 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_dcmp  in  DATA_WIDTH  head word of FIFO A (peek, unregistered).
- a_empty  in  1  FIFO A empty.
- a_rd_en  out  1  pop FIFO A this cycle (combinational).
- b_dcmp  in  DATA_WIDTH  head word of FIFO B.
- b_empty  in  1  FIFO B empty.
- b_rd_en  out  1  pop FIFO B this cycle (combinational).
- out_data  out  DATA_WIDTH  merged word (registered).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts word when out_valid & out_ready.
- out_last  out  1  marks final word of a merged run (qualified by out_valid).
- busy  out  1  high when state != MERGE or cnt_a/cnt_b nonzero (run in progress).

Behaviour:
- Reset (reset=0, async): state=MERGE, cnt_a=cnt_b=0, out_data=0, out_valid=0, out_last=0. a_rd_en=b_rd_en=0 while reset asserted. Reset mid-run discards the partial run; FIFOs are not rewound.
- Counters cnt_a, cnt_b: LOG2_RUN+1 bits; count words taken from the current A/B run.
- can_load = !out_valid | out_ready. The output register loads only when can_load is true.
- State MERGE:
  - If can_load & !a_empty & !b_empty: pop A when a_dcmp <= b_dcmp (tie takes A, stable), else pop B. Popped word goes to out_data; out_valid=1; matching counter increments.
  - If the pop makes cnt_a==RUN -> DRAIN_B; if cnt_b==RUN -> DRAIN_A.
  - With either FIFO empty, no pop and no decision; wait.
- State DRAIN_A: pop A whenever can_load & !a_empty; b_empty and b_dcmp are ignored. When cnt_a reaches RUN: out_last=1 on that word, clear both counters, return to MERGE.
- State DRAIN_B: symmetric to DRAIN_A.
- At most one of a_rd_en/b_rd_en is high in any cycle. rd_en is never asserted when the matching empty is high.
- Output hold: if out_valid & !out_ready, out_data/out_last hold and no pop occurs.
- out_valid drops to 0 after a handshake in a cycle with no new load.
- out_last clears on any load of a non-final word.
- Latency: one cycle from pop (rd_en high) to word visible on out_data. Full throughput of one word/cycle with out_ready held high.
- LOG2_RUN=0: each run is one word. Sequence is MERGE -> DRAIN_x for one word, with out_last on the second word.

Optional Feature:
- MERGE_DESCEND_EN:
  - Defined: inputs are descending runs. Select A when a_dcmp >= b_dcmp (tie still A); output is descending.
  - Undefined: ascending behaviour as above.
  - All other timing is identical.

Test Plan:
- Basic merge, LOG2_RUN=2, out_ready=1:
  - Stimulus: A={1,4,6,9}, B={2,3,7,8}.
  - Response: out = 1,2,3,4,6,7,8,9 on 8 consecutive cycles; out_last only on 9; busy low afterwards.
- Ties/stability:
  - Stimulus: A={5,5,5,5}, B={5,5,5,5}, A tagged in upper bits only if keys compared exclude tag.
  - Response: the 4 A pops precede the 4 B pops; a_rd_en is high for 4 consecutive cycles.
- Drain path:
  - Stimulus: A={1,2,3,4}, B={10,11,12,13}.
  - Response: after 4 A pops the state is DRAIN_B; 10..13 follow; a_empty toggling during drain does not stall.
- Backpressure:
  - Stimulus: same as basic, with out_ready low for 3 cycles after the first valid.
  - Response: out_data holds 1, no rd_en during the stall, order unchanged, no word lost or duplicated.
- Empty stall:
  - Stimulus: B empty for 5 cycles while A is nonempty in MERGE.
  - Response: no pops, out_valid drops after the pending handshake, merging resumes the cycle b_empty falls.
- Async reset mid-run:
  - Stimulus: assert reset after 3 outputs, release.
  - Response: out_valid=0, out_last=0, rd_en=0 immediately (no clock edge); the next merge starts with counters at 0.

Source files
------------

// File: rtl/merge2_stage.sv
// ---------------------------------------------------------------------------
// merge2_stage
// Two-way merge of sorted runs held in two upstream fifo16 buffers. Both heads
// are peeked through dcmp/empty; the smaller head (or larger, when built
// descending) is popped and registered onto a valid/ready output. Each pair of
// RUN-word input runs yields one 2*RUN-word merged run, last word flagged.
//
// Optional build macro: MERGE_DESCEND_EN
//   undefined : ascending runs, pick A when a_dcmp <= b_dcmp
//   defined   : descending runs, pick A when a_dcmp >= b_dcmp
//   Ties always pick A, so the merge is stable.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   a_dcmp     in   head word of FIFO A (unregistered peek)
//   a_empty    in   FIFO A empty
//   a_rd_en    out  pop FIFO A this cycle (combinational)
//   b_dcmp     in   head word of FIFO B
//   b_empty    in   FIFO B empty
//   b_rd_en    out  pop FIFO B this cycle (combinational)
//   out_data   out  merged word (registered)
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts on out_valid & out_ready
//   out_last   out  final word of a merged run (qualified by out_valid)
//   busy       out  a merged run is in progress
// ---------------------------------------------------------------------------
module merge2_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2_RUN   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a_dcmp,
  input  logic                  a_empty,
  output logic                  a_rd_en,
  input  logic [DATA_WIDTH-1:0] b_dcmp,
  input  logic                  b_empty,
  output logic                  b_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int unsigned CNT_W = LOG2_RUN + 1;
  localparam logic [CNT_W-1:0] RUN = CNT_W'(1 << LOG2_RUN);

  typedef enum logic [1:0] {
    S_MERGE   = 2'd0,
    S_DRAIN_A = 2'd1,
    S_DRAIN_B = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt_a;
  logic [CNT_W-1:0]      r_cnt_b;
  logic [CNT_W-1:0]      w_cnt_a_nxt;
  logic [CNT_W-1:0]      w_cnt_b_nxt;
  logic [CNT_W-1:0]      w_cnt_a_inc;
  logic [CNT_W-1:0]      w_cnt_b_inc;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  w_can_load;
  logic                  w_take_a;
  logic                  w_pop_a;
  logic                  w_pop_b;
  logic                  w_last_nxt;

  // Output register can accept a new word when empty or being drained now.
  assign w_can_load  = !r_out_valid || out_ready;
  assign w_cnt_a_inc = r_cnt_a + CNT_W'(1);
  assign w_cnt_b_inc = r_cnt_b + CNT_W'(1);

  // Head selection; ties go to A to keep the merge stable.
`ifdef MERGE_DESCEND_EN
  assign w_take_a = (a_dcmp >= b_dcmp);
`else
  assign w_take_a = (a_dcmp <= b_dcmp);
`endif

  // Next-state, pop and counter decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    w_pop_a     = 1'b0;
    w_pop_b     = 1'b0;
    w_last_nxt  = 1'b0;
    case (r_state)
      S_MERGE: begin
        if (w_can_load && !a_empty && !b_empty) begin
          if (w_take_a) begin
            w_pop_a     = 1'b1;
            w_cnt_a_nxt = w_cnt_a_inc;
            if (w_cnt_a_inc == RUN) w_state_nxt = S_DRAIN_B;
          end else begin
            w_pop_b     = 1'b1;
            w_cnt_b_nxt = w_cnt_b_inc;
            if (w_cnt_b_inc == RUN) w_state_nxt = S_DRAIN_A;
          end
        end
      end
      S_DRAIN_A: begin
        if (w_can_load && !a_empty) begin
          w_pop_a = 1'b1;
          if (w_cnt_a_inc == RUN) begin
            w_last_nxt  = 1'b1;
            w_cnt_a_nxt = '0;
            w_cnt_b_nxt = '0;
            w_state_nxt = S_MERGE;
          end else begin
            w_cnt_a_nxt = w_cnt_a_inc;
          end
        end
      end
      S_DRAIN_B: begin
        if (w_can_load && !b_empty) begin
          w_pop_b = 1'b1;
          if (w_cnt_b_inc == RUN) begin
            w_last_nxt  = 1'b1;
            w_cnt_a_nxt = '0;
            w_cnt_b_nxt = '0;
            w_state_nxt = S_MERGE;
          end else begin
            w_cnt_b_nxt = w_cnt_b_inc;
          end
        end
      end
      default: begin
        w_state_nxt = S_MERGE;
      end
    endcase
  end

  // Pops are suppressed combinationally while reset is held.
  assign a_rd_en = reset && w_pop_a;
  assign b_rd_en = reset && w_pop_b;

  // State and run counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_MERGE;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt_a <= w_cnt_a_nxt;
      r_cnt_b <= w_cnt_b_nxt;
    end
  end

  // Output register: load on pop, otherwise drop valid once accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_pop_a || w_pop_b) begin
      r_out_data  <= w_pop_a ? a_dcmp : b_dcmp;
      r_out_valid <= 1'b1;
      r_out_last  <= w_last_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_MERGE) || (r_cnt_a != '0) || (r_cnt_b != '0);

endmodule
